// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: single-port 64-bit SRAM slave on a simple valid/addr_ok/data_ok bus.
// Each transaction is accepted in IDLE. It waits a fixed LATENCY, then completes with one data_ok pulse.
// Optional feature macro: DBUS_RESP_JITTER_EN adds 0..3 LFSR-chosen extra wait cycles per transaction.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic [15:0] err_count
);
  localparam int AW = $clog2(DEPTH);
`ifdef DBUS_RESP_JITTER_EN
  // One extra bit so that LATENCY-1 plus a jitter of up to 3 cannot wrap.
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, load_val;
  logic [63:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]      strb_q, strb_d;
  logic [15:0]     err_q, err_d;
  logic [63:0]     mem [DEPTH];

  logic [63:0]     tx_addr, tx_wdata, off;
  logic [7:0]      tx_strb;
  logic            in_range, go_resp, mem_we;
  logic [AW-1:0]   idx;

`ifdef DBUS_RESP_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign load_val = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
  assign load_val = CW'(LATENCY - 1);
`endif

  // With LATENCY==1 the memory access happens on the acceptance edge itself.
  // In that case the live request fields are used instead of the latched copy.
  assign tx_addr  = (state_q == IDLE) ? dreq.addr   : addr_q;
  assign tx_strb  = (state_q == IDLE) ? dreq.strobe : strb_q;
  assign tx_wdata = (state_q == IDLE) ? dreq.data   : wdata_q;

  assign off      = tx_addr - BASE_ADDR;
  assign in_range = (tx_addr >= BASE_ADDR) && (off[63:3] < 61'(DEPTH));
  assign idx      = off[AW+2:3];

  logic unused_ok;
  assign unused_ok = ^{dreq.size, off[2:0]};

  // Next-state, counter, request latch and the access performed on the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    err_d   = err_q;
    go_resp = 1'b0;
    mem_we  = 1'b0;
`ifdef DBUS_RESP_JITTER_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      IDLE: if (dreq.valid) begin
        addr_d  = dreq.addr;
        strb_d  = dreq.strobe;
        wdata_d = dreq.data;
        cnt_d   = load_val;
`ifdef DBUS_RESP_JITTER_EN
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
        if (load_val == '0) go_resp = 1'b1;
        else                state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) go_resp = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      state_d = RESP;
      if (!in_range) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end else if (tx_strb != 8'h00) begin
        mem_we = 1'b1;
      end else begin
        rdata_d = mem[idx];
      end
    end
  end

  // Control and data registers; memory contents are outside this reset domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
`ifdef DBUS_RESP_JITTER_EN
      lfsr_q  <= 16'hACE1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DBUS_RESP_JITTER_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Byte-masked write; suppressed when reset lands on the write edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 8; b++)
        if (tx_strb[b]) mem[idx][b*8 +: 8] <= tx_wdata[b*8 +: 8];
    end
  end

  assign dresp.addr_ok = (state_q == IDLE);
  assign dresp.data_ok = (state_q == RESP);
  assign dresp.data    = rdata_q;
  assign err_count     = err_q;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder (LATENCY=2, DEPTH=1024).
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic [15:0] err_count;

  int n_run = 0;
  int n_fail = 0;

  dbus_sram_responder #(.DEPTH(1024), .LATENCY(LAT), .BASE_ADDR(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] exp;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[15];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Issue one request and return the data seen in its data_ok cycle.
  // lat counts cycles from the acceptance edge to data_ok.
  task automatic txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                     output logic [63:0] rd, output int lat);
    int w;
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = a; dreq.strobe = s; dreq.data = d; dreq.size = 3'd3;
    w = 0;
    while (!dresp.addr_ok && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    // Scramble the request after acceptance; the DUT must use its latched copy.
    dreq.valid = 1'b0; dreq.addr = '1; dreq.strobe = '1; dreq.data = '1;
    if (LAT > 1) begin
      chk("wait_addr_ok_low", 64'(dresp.addr_ok), 64'd0);
      chk("wait_data_zero", dresp.data, 64'd0);
    end
    lat = 1;
    while (!dresp.data_ok && lat < 20) begin @(negedge clk); lat++; end
    rd = dresp.data;
  endtask

  initial begin
    logic [63:0] rd;
    int lat, acc, oks, last, per_bad, overlap, bad_data, seen;

    vecs[0]  = '{64'h8000_0008, 8'hFF, 64'h1122334455667788, 64'h0, 16'd0};
    vecs[1]  = '{64'h8000_0008, 8'h00, 64'h0, 64'h1122334455667788, 16'd0};
    vecs[2]  = '{64'h8000_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 64'h0, 16'd0};
    vecs[3]  = '{64'h8000_0008, 8'h00, 64'h0, 64'h11223344_BBBBBBBB, 16'd0};
    vecs[4]  = '{64'h8000_000F, 8'h00, 64'h0, 64'h11223344_BBBBBBBB, 16'd0};
    vecs[5]  = '{64'h8000_0000, 8'hFF, 64'h0, 64'h0, 16'd0};
    vecs[6]  = '{64'h8000_0000, 8'h81, 64'hDEADBEEF_CAFEF00D, 64'h0, 16'd0};
    vecs[7]  = '{64'h8000_0000, 8'h00, 64'h0, 64'hDE000000_0000000D, 16'd0};
    vecs[8]  = '{64'h8000_1FF8, 8'hFF, 64'h01234567_89ABCDEF, 64'h0, 16'd0};
    vecs[9]  = '{64'h8000_1FF8, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 16'd0};
    vecs[10] = '{64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, 16'd1};
    vecs[11] = '{64'h8000_2000, 8'h00, 64'h0, 64'h0, 16'd2};
    vecs[12] = '{64'h8000_2000, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 16'd3};
    vecs[13] = '{64'h8000_0000, 8'h00, 64'h0, 64'hDE000000_0000000D, 16'd3};
    vecs[14] = '{64'h8000_1FF8, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 16'd3};

    reset = 1'b1;
    dreq = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_addr_ok", 64'(dresp.addr_ok), 64'd1);
    chk("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    chk("rst_data", dresp.data, 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);

    for (int i = 0; i < 15; i++) begin
      txn(vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, lat);
`ifdef DBUS_RESP_JITTER_EN
      chk($sformatf("v%0d_latency_range", i), 64'(lat >= LAT && lat <= LAT + 3), 64'd1);
`else
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
`endif
      chk($sformatf("v%0d_data", i), rd, vecs[i].exp);
      chk($sformatf("v%0d_err", i), 64'(err_count), 64'(vecs[i].exp_err));
    end

    // valid held high: one completion per acceptance, fixed period LATENCY+1.
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0008; dreq.strobe = 8'h00; dreq.data = '0;
    acc = 0; oks = 0; last = -1; per_bad = 0; overlap = 0; bad_data = 0;
    for (int c = 0; c < 16; c++) begin
      if (dresp.data_ok) begin
        oks++;
        if (dresp.data !== 64'h11223344_BBBBBBBB) bad_data++;
        if (last >= 0 && c - last != LAT + 1) per_bad++;
        last = c;
      end
      if (dresp.addr_ok && dresp.data_ok) overlap++;
      if (dresp.addr_ok) acc++;
      @(negedge clk);
    end
    dreq.valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (dresp.data_ok) oks++;
      @(negedge clk);
    end
`ifndef DBUS_RESP_JITTER_EN
    chk("b2b_accepts", 64'(acc), 64'd6);
    chk("b2b_period", 64'(per_bad), 64'd0);
`endif
    chk("b2b_one_ok_per_accept", 64'(oks), 64'(acc));
    chk("b2b_no_overlap", 64'(overlap), 64'd0);
    chk("b2b_data", 64'(bad_data), 64'd0);

    // Reset one cycle after accepting a write: the write must be dropped.
    txn(64'h8000_0010, 8'hFF, 64'h55555555_55555555, rd, lat);
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010; dreq.strobe = 8'hFF;
    dreq.data = 64'h99999999_99999999;
    @(negedge clk);
    dreq.valid = 1'b0;
    reset = 1'b1;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (dresp.data_ok) seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    if (dresp.data_ok) seen++;
    chk("rst_mid_no_data_ok", 64'(seen), 64'd0);
    chk("rst_mid_addr_ok", 64'(dresp.addr_ok), 64'd1);
    chk("rst_mid_err_cleared", 64'(err_count), 64'd0);
    txn(64'h8000_0010, 8'h00, 64'h0, rd, lat);
    chk("rst_mid_word_unchanged", rd, 64'h55555555_55555555);
    txn(64'h8000_0000, 8'h00, 64'h0, rd, lat);
    chk("rst_mem_retained", rd, 64'hDE000000_0000000D);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
